// File: rtl/sauria_fp_pkg.sv
// Shared floating-point definitions for the SAURIA datapath blocks.
// It holds the FP16 and FP32 field widths, the exponent biases, the constants
// used for FP16 -> FP32 widening, the operand class enum, the decoded-lane
// struct and a classification helper.
package sauria_fp_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_MAN_W   = 10;
    localparam int FP32_EXP_W   = 8;
    localparam int FP32_MAN_W   = 23;

    localparam int FP16_BIAS    = 15;
    localparam int FP32_BIAS    = 127;
    localparam int BIAS_DELTA   = FP32_BIAS - FP16_BIAS;          // 112
    // A subnormal m * 2^-24 with its MSB at bit p is 1.f * 2^(p-24).
    // Its FP32 biased exponent is therefore p - 24 + 127 = 103 + p.
    localparam int SUB_EXP_BASE = BIAS_DELTA - FP16_MAN_W + 1;    // 103

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    localparam int LZ_POS_W = $clog2(FP16_MAN_W);                 // 4

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // One FP16 lane after decode, as held in the first pipeline stage.
    typedef struct packed {
        logic                  sign;
        logic [FP16_EXP_W-1:0] exp;
        logic [FP16_MAN_W-1:0] man;
        logic [LZ_POS_W-1:0]   lz_pos;
        fp_class_e             cls;
    } fp16_dec_t;

    function automatic fp_class_e fp16_classify(input logic [FP16_EXP_W-1:0] exp,
                                                input logic                  man_zero);
        if (exp == '0)
            return man_zero ? FP_ZERO : FP_SUB;
        if (exp == '1)
            return man_zero ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

endpackage

// File: rtl/sauria_lzc.sv
// Combinational leading-one detector.
//   data : input vector
//   pos  : index of the most significant set bit (0 when data is zero)
//   zero : data has no bit set
module sauria_lzc #(
    parameter  int WIDTH = 10,
    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Ascending scan: the last assignment belongs to the highest set bit.
    always_comb begin
        pos = '0;
        for (int i = 0; i < WIDTH; i++)
            if (data[i]) pos = POS_W'(i);
    end

    assign zero = ~|data;

endmodule

// File: rtl/fp16_to_fp32_stream.sv
// Multi-lane FP16 -> FP32 widening converter with a valid/ready stream interface.
// The conversion is exact. Subnormals are normalised, NaNs are quieted, and
// optional flush-to-zero and canonical-NaN modes are sampled with each beat.
// Pipeline: S1 = decoded lanes, S2 = assembled FP32 result (2-cycle latency).
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : input handshake; in_data_i lane k = [16k+15:16k]
//   ftz_i, canon_nan_i    : per-beat mode bits
//   out_valid_o/out_ready_i, out_data_o : output handshake, lane k = [32k+31:32k]
//   clr_status_i          : clears the sticky flags (a same-cycle set wins)
//   nan/sub/inf_seen_o    : sticky class flags, updated on output transfers
module fp16_to_fp32_stream
    import sauria_fp_pkg::*;
#(
    parameter int LANES        = 4,
    parameter bit CANON_NAN_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [16*LANES-1:0] in_data_i,
    input  logic               ftz_i,
    input  logic               canon_nan_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [32*LANES-1:0] out_data_o,
    input  logic               clr_status_i,
    output logic               nan_seen_o,
    output logic               sub_seen_o,
    output logic               inf_seen_o
);

    localparam int STAGES = 2;

    logic [STAGES:1]            vld_pipe;
    logic                       adv1, adv2, out_hs;

    logic [LANES-1:0][15:0]     lane_in;
    logic [LANES-1:0][LZ_POS_W-1:0] lz_pos;
    logic [LANES-1:0]           lz_zero;
    fp16_dec_t [LANES-1:0]      dec;

    fp16_dec_t [LANES-1:0]      s1_q;
    logic                       s1_ftz, s1_canon;
    logic                       s1_nan, s1_sub, s1_inf;
    logic [LANES-1:0][31:0]     asm_d;

    logic [LANES-1:0][31:0]     s2_data;
    logic                       s2_nan, s2_sub, s2_inf;
    logic                       nan_q, sub_q, inf_q;

    // Handshake. The path from out_ready_i to in_ready_o is combinational,
    // so a full pipe accepts a new beat in the same cycle that it drains one.
    assign adv2       = !vld_pipe[2] || out_ready_i;
    assign adv1       = !vld_pipe[1] || adv2;
    assign in_ready_o = adv1;
    assign out_hs     = vld_pipe[2] && out_ready_i;

    assign lane_in = in_data_i;

    // Decode in front of S1
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sauria_lzc #(.WIDTH(FP16_MAN_W)) u_lzc (
            .data (lane_in[g][FP16_MAN_W-1:0]),
            .pos  (lz_pos[g]),
            .zero (lz_zero[g])
        );
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            dec[l].sign   = lane_in[l][15];
            dec[l].exp    = lane_in[l][14:10];
            dec[l].man    = lane_in[l][9:0];
            dec[l].lz_pos = lz_pos[l];
            dec[l].cls    = fp16_classify(lane_in[l][14:10], lz_zero[l]);
        end
    end

    // Assembly in front of S2
    function automatic logic [31:0] assemble(input fp16_dec_t l,
                                             input logic      ftz,
                                             input logic      canon);
        logic [FP16_MAN_W-1:0] frac;
        logic [31:0]           res;
        // Shift the leading one out of the 10-bit field. What remains is the
        // fraction below the implicit bit.
        frac = l.man << (LZ_POS_W'(FP16_MAN_W) - l.lz_pos);
        res  = {l.sign, 31'b0};
        case (l.cls)
            FP_SUB:  if (!ftz)
                         res = {l.sign, 8'(SUB_EXP_BASE + int'(l.lz_pos)), frac, 13'b0};
            FP_NORM: res = {l.sign, 8'(BIAS_DELTA + int'(l.exp)), l.man, 13'b0};
            FP_INF:  res = {l.sign, 8'hFF, 23'b0};
            FP_NAN:  res = canon ? FP32_QNAN : {l.sign, 8'hFF, 1'b1, l.man[8:0], 13'b0};
            default: res = {l.sign, 31'b0};
        endcase
        return res;
    endfunction

    always_comb begin
        s1_nan = 1'b0;
        s1_sub = 1'b0;
        s1_inf = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            asm_d[l] = assemble(s1_q[l], s1_ftz, s1_canon);
            s1_nan   = s1_nan | (s1_q[l].cls == FP_NAN);
            s1_sub   = s1_sub | (s1_q[l].cls == FP_SUB);
            s1_inf   = s1_inf | (s1_q[l].cls == FP_INF);
        end
    end

    // Pipeline registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s1_ftz   <= 1'b0;
            s1_canon <= 1'b0;
            s2_data  <= '0;
            s2_nan   <= 1'b0;
            s2_sub   <= 1'b0;
            s2_inf   <= 1'b0;
        end else begin
            if (adv1) begin
                vld_pipe[1] <= in_valid_i;
                if (in_valid_i) begin
                    s1_q     <= dec;
                    s1_ftz   <= ftz_i;
                    // When the mode is absent, the register ties off to 0 and is trimmed.
                    s1_canon <= canon_nan_i & CANON_NAN_EN;
                end
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    s2_data <= asm_d;
                    s2_nan  <= s1_nan;
                    s2_sub  <= s1_sub;
                    s2_inf  <= s1_inf;
                end
            end
        end
    end

    // Sticky status. A set from a transferred beat takes priority over the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nan_q <= 1'b0;
            sub_q <= 1'b0;
            inf_q <= 1'b0;
        end else begin
            nan_q <= (nan_q & ~clr_status_i) | (out_hs & s2_nan);
            sub_q <= (sub_q & ~clr_status_i) | (out_hs & s2_sub);
            inf_q <= (inf_q & ~clr_status_i) | (out_hs & s2_inf);
        end
    end

    assign out_valid_o = vld_pipe[2];
    assign out_data_o  = s2_data;
    assign nan_seen_o  = nan_q;
    assign sub_seen_o  = sub_q;
    assign inf_seen_o  = inf_q;

endmodule

// File: tb/tb_fp16_to_fp32_stream.sv
module tb_fp16_to_fp32_stream;

    localparam int LANES = 4;
    localparam int IW    = 16 * LANES;
    localparam int DW    = 32 * LANES;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          ftz = 1'b0;
    logic          canon = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          clr = 1'b0;
    logic          nan_seen, sub_seen, inf_seen;

    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    fp16_to_fp32_stream #(.LANES(LANES), .CANON_NAN_EN(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .ftz_i        (ftz),
        .canon_nan_i  (canon),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .clr_status_i (clr),
        .nan_seen_o   (nan_seen),
        .sub_seen_o   (sub_seen),
        .inf_seen_o   (inf_seen)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            acc_cyc;
        bit            chk_lat;
        bit            has_nan, has_sub, has_inf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the value of the FP16 number is formed as a real number and
    // re-encoded from the IEEE double bit pattern. All FP16 values are exact in FP32.
    function automatic logic [31:0] ref32(input logic [15:0] h, input bit f, input bit c);
        logic        s;
        int          e, m, e32;
        real         v;
        logic [63:0] b;
        s = h[15];
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 31) begin
            if (m == 0) return {s, 8'hFF, 23'h0};
            if (c)      return 32'h7FC0_0000;
            return {s, 8'hFF, 1'b1, h[8:0], 13'h0};
        end
        if (e == 0 && (m == 0 || f)) return {s, 31'h0};
        if (e == 0) v = real'(m) * (2.0 ** (-24));
        else        v = real'(1024 + m) * (2.0 ** (e - 25));
        b   = $realtobits(v);
        e32 = int'(b[62:52]) - 1023 + 127;
        return {s, e32[7:0], b[51:29]};
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] h;
        h = 16'($urandom);
        case ($urandom_range(0, 5))
            0: h[14:10] = 5'd0;
            1: h[14:10] = 5'd31;
            2: h[9:0]   = 10'd0;
            default: ;
        endcase
        return h;
    endfunction

    // Offer one beat, push its expectation when it is accepted, and release in_valid.
    task automatic send(input logic [IW-1:0] d, input bit f, input bit c,
                        input bit lat, input logic [DW-1:0] expd);
        exp_t x;
        int   waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        ftz      = f;
        canon    = c;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                x.data    = expd;
                x.acc_cyc = cyc;
                x.chk_lat = lat;
                x.has_nan = 1'b0;
                x.has_sub = 1'b0;
                x.has_inf = 1'b0;
                for (int l = 0; l < LANES; l++) begin
                    if (d[16*l+10 +: 5] == 5'd31 && d[16*l +: 10] != 0) x.has_nan = 1'b1;
                    if (d[16*l+10 +: 5] == 5'd31 && d[16*l +: 10] == 0) x.has_inf = 1'b1;
                    if (d[16*l+10 +: 5] == 5'd0  && d[16*l +: 10] != 0) x.has_sub = 1'b1;
                end
                sb.push_back(x);
                break;
            end
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", waited);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit lat);
        logic [IW-1:0] d;
        logic [DW-1:0] e;
        bit            f, c;
        f = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        for (int l = 0; l < LANES; l++) begin
            d[16*l +: 16] = rnd16();
            e[32*l +: 32] = ref32(d[16*l +: 16], f, c);
        end
        send(d, f, c, lat, e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d beats still outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor and scoreboard
    int            inflight = 0;
    bit            e_nan = 0, e_sub = 0, e_inf = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        exp_t x;
        bit   hs_out, hs_in;
        if (rst_i) begin
            sb.delete();
            inflight   = 0;
            e_nan      = 0;
            e_sub      = 0;
            e_inf      = 0;
            prev_stall = 0;
        end else begin
            chk("sticky_flags{nan,sub,inf}", DW'({nan_seen, sub_seen, inf_seen}),
                DW'({e_nan, e_sub, e_inf}));
            chk("in_ready", DW'(in_ready), DW'(!(inflight == 2 && !out_ready)));
            if (prev_stall) begin
                chk("stall_valid_hold", DW'(out_valid), DW'(1));
                chk("stall_data_hold", out_data, prev_data);
            end
            hs_out = out_valid && out_ready;
            hs_in  = in_valid && in_ready;
            if (!e_nan || clr) e_nan = 0;
            if (!e_sub || clr) e_sub = 0;
            if (!e_inf || clr) e_inf = 0;
            if (out_valid && sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_output: got valid beat %h expected none", out_data);
            end else if (hs_out) begin
                x = sb.pop_front();
                chk("out_data", out_data, x.data);
                if (x.chk_lat) chk("latency", DW'(cyc - x.acc_cyc), DW'(2));
                if (x.has_nan) e_nan = 1;
                if (x.has_sub) e_sub = 1;
                if (x.has_inf) e_inf = 1;
            end
            inflight   = inflight + int'(hs_in) - int'(hs_out);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Directed vectors: the value is replicated in every lane.
    typedef struct {
        logic [15:0] h;
        bit          f, c;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[13] = '{
        '{16'h3C00, 0, 0, 32'h3F80_0000},
        '{16'hC000, 0, 0, 32'hC000_0000},
        '{16'h7BFF, 0, 0, 32'h477F_E000},
        '{16'h8000, 0, 0, 32'h8000_0000},
        '{16'h0001, 0, 0, 32'h3380_0000},
        '{16'h03FF, 0, 0, 32'h387F_C000},
        '{16'h8200, 0, 0, 32'hB800_0000},
        '{16'h8001, 1, 0, 32'h8000_0000},
        '{16'h0001, 0, 0, 32'h3380_0000},
        '{16'h7C00, 0, 0, 32'h7F80_0000},
        '{16'hFC00, 0, 0, 32'hFF80_0000},
        '{16'h7C01, 0, 0, 32'h7FC0_2000},
        '{16'hFE00, 0, 1, 32'h7FC0_0000}
    };

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", DW'(out_valid), DW'(0));
        chk("reset_out_data", out_data, DW'(0));
        chk("reset_flags", DW'({nan_seen, sub_seen, inf_seen}), DW'(0));
        chk("reset_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;

        foreach (vecs[i])
            send({LANES{vecs[i].h}}, vecs[i].f, vecs[i].c, 1'b1, {LANES{vecs[i].r}});
        drain();
        chk("directed_flags", DW'({nan_seen, sub_seen, inf_seen}), DW'(3'b111));

        // Clear alone, then a clear coinciding with a NaN beat transfer
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clear_flags", DW'({nan_seen, sub_seen, inf_seen}), DW'(3'b000));
        @(posedge clk);
        #1;
        send({LANES{16'hFE00}}, 1'b0, 1'b0, 1'b1, {LANES{32'hFFC0_0000}});
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("set_beats_clear", DW'({nan_seen, sub_seen, inf_seen}), DW'(3'b100));
        drain();

        // Random stream under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_rand(1'b0);
        for (int i = 0; i < 60; i++) begin
            send_rand(1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        rand_ready = 1'b0;

        // Random stream at full rate with latency checks
        for (int i = 0; i < 20; i++) send_rand(1'b1);
        send({LANES{16'h7E00}}, 1'b0, 1'b0, 1'b1, {LANES{32'h7FC0_0000}});
        drain();

        // Reset with two beats in flight
        send({LANES{16'h3C00}}, 1'b0, 1'b0, 1'b1, {LANES{32'h3F80_0000}});
        send({LANES{16'h7C00}}, 1'b0, 1'b0, 1'b1, {LANES{32'h7F80_0000}});
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", DW'(out_valid), DW'(0));
        chk("midreset_flags", DW'({nan_seen, sub_seen, inf_seen}), DW'(0));
        chk("midreset_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
        send({LANES{16'h0001}}, 1'b0, 1'b0, 1'b1, {LANES{32'h3380_0000}});
        drain();
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog");
    end

endmodule
